// File: rtl/rib_timer.sv
// RIB slave timer: up-counter with compare, auto-reload/one-shot modes and a level interrupt.
// Optional prescaler is built only when RIB_TIMER_PRESC_EN is defined.
module rib_timer #(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        we_i,
  output logic        int_sig_o
);

  localparam logic [1:0] A_CTRL  = 2'd0;
  localparam logic [1:0] A_COUNT = 2'd1;
  localparam logic [1:0] A_CMP   = 2'd2;
  localparam logic [1:0] A_PRESC = 2'd3;

  logic             en_q, en_d;
  logic             ie_q, ie_d;
  logic             ar_q, ar_d;
  logic             pend_q, pend_d;
  logic             int_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;

  logic             wr_ctrl, wr_count, wr_cmp, wr_presc;
  logic             tick, tick_eff, match;
  logic [31:0]      count_ext, cmp_ext, presc_ext;

  assign wr_ctrl  = we_i && (addr_i[3:2] == A_CTRL);
  assign wr_count = we_i && (addr_i[3:2] == A_COUNT);
  assign wr_cmp   = we_i && (addr_i[3:2] == A_CMP);
  assign wr_presc = we_i && (addr_i[3:2] == A_PRESC);

`ifdef RIB_TIMER_PRESC_EN
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pcnt_q;

  assign tick = en_q && (pcnt_q == presc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      if (wr_presc) presc_q <= data_i[PRESC_W-1:0];
      if (!en_q || wr_presc || tick) pcnt_q <= '0;
      else                           pcnt_q <= pcnt_q + PRESC_W'(1);
    end
  end

  always_comb begin
    presc_ext = '0;
    presc_ext[PRESC_W-1:0] = presc_q;
  end
`else
  logic [PRESC_W-1:0] unused_presc_w;
  logic               unused_wr_presc;

  assign unused_presc_w  = '0;
  assign unused_wr_presc = wr_presc;
  assign tick            = en_q;
  assign presc_ext       = '0;
`endif

  assign match = (count_q == cmp_q);
  // A CTRL write that clears EN discards a tick landing on the same edge.
  assign tick_eff = tick && !(wr_ctrl && !data_i[0]);

  always_comb begin
    en_d    = en_q;
    ie_d    = ie_q;
    ar_d    = ar_q;
    pend_d  = pend_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    if (tick_eff) begin
      if (match) begin
        pend_d = 1'b1;
        if (ar_q) count_d = '0;
        else      en_d    = 1'b0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
    if (wr_ctrl) begin
      en_d = data_i[0];
      ie_d = data_i[1];
      ar_d = data_i[2];
      // Hardware set of PEND beats a simultaneous write-1-to-clear.
      if (data_i[3] && !(tick_eff && match)) pend_d = 1'b0;
    end
    if (wr_count) count_d = data_i[CNT_W-1:0];
    if (wr_cmp)   cmp_d   = data_i[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      ie_q    <= 1'b0;
      ar_q    <= 1'b0;
      pend_q  <= 1'b0;
      int_q   <= 1'b0;
      count_q <= '0;
      cmp_q   <= '1;
    end else begin
      en_q    <= en_d;
      ie_q    <= ie_d;
      ar_q    <= ar_d;
      pend_q  <= pend_d;
      int_q   <= pend_q & ie_q;
      count_q <= count_d;
      cmp_q   <= cmp_d;
    end
  end

  assign int_sig_o = int_q;

  always_comb begin
    count_ext = '0;
    count_ext[CNT_W-1:0] = count_q;
    cmp_ext = '0;
    cmp_ext[CNT_W-1:0] = cmp_q;
  end

  always_comb begin
    data_o = '0;
    case (addr_i[3:2])
      A_CTRL:  data_o = {28'd0, pend_q, ar_q, ie_q, en_q};
      A_COUNT: data_o = count_ext;
      A_CMP:   data_o = cmp_ext;
      default: data_o = presc_ext;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{addr_i[31:4], addr_i[1:0], data_i};

endmodule

// File: tb/tb_rib_timer.sv
// Directed bench for rib_timer: reset values, auto-reload, collisions, wrap/alias,
// one-shot (with prescaler when RIB_TIMER_PRESC_EN is defined) and async reset.
module tb_rib_timer;

  localparam logic [31:0] R_CTRL  = 32'h2000_0000;
  localparam logic [31:0] R_COUNT = 32'h2000_0004;
  localparam logic [31:0] R_CMP   = 32'h2000_0008;
  localparam logic [31:0] R_PRESC = 32'h2000_000C;
`ifdef RIB_TIMER_PRESC_EN
  localparam int P = 2;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        we_i = 1'b0;
  logic        int_sig_o;

  int nchecks = 0;
  int nerrors = 0;

  rib_timer dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .we_i      (we_i),
    .int_sig_o (int_sig_o)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    assert (got === exp) else begin
      nerrors++;
      $display("FAIL %s: observed=%h expected=%h", tag, got, exp);
      $error("check %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr_i = a;
    #1;
    d = data_o;
  endtask

  // Called just after a negedge; returns at the following negedge (after the commit edge).
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    @(negedge clk);
    we_i   = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] exp_ar [4];
    int          kmax;
    int          ec;
    exp_ar = '{32'd1, 32'd2, 32'd3, 32'd0};

    // reset values
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd(R_CTRL, v);  check("rst_ctrl", v, 32'h0);
    rd(R_COUNT, v); check("rst_count", v, 32'h0);
    rd(R_CMP, v);   check("rst_cmp", v, 32'hFFFF_FFFF);
    rd(R_PRESC, v); check("rst_presc", v, 32'h0);
    check("rst_int", {31'd0, int_sig_o}, 32'h0);

    // auto-reload, every cycle
    wr(R_CMP, 32'd3);
    wr(R_CTRL, 32'h7);
    rd(R_COUNT, v); check("ar_start", v, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd(R_COUNT, v); check("ar_count", v, exp_ar[i]);
    end
    rd(R_CTRL, v); check("ar_pend", v, 32'hF);
    check("ar_int_lag", {31'd0, int_sig_o}, 32'h0);
    @(negedge clk);
    rd(R_COUNT, v); check("ar_count_again", v, 32'd1);
    check("ar_int_rise", {31'd0, int_sig_o}, 32'h1);

    // W1C of PEND, int drops one cycle later
    wr(R_CTRL, 32'hF);
    rd(R_CTRL, v);  check("w1c_ctrl", v, 32'h7);
    rd(R_COUNT, v); check("w1c_count", v, 32'd2);
    check("w1c_int_hold", {31'd0, int_sig_o}, 32'h1);
    @(negedge clk);
    check("w1c_int_drop", {31'd0, int_sig_o}, 32'h0);
    rd(R_COUNT, v); check("w1c_count3", v, 32'd3);

    // W1C on the same edge as a match: set wins
    wr(R_CTRL, 32'hF);
    rd(R_CTRL, v);  check("coll_pend", v, 32'hF);
    rd(R_COUNT, v); check("coll_reload", v, 32'd0);

    // COUNT write on a tick edge: write wins
    wr(R_COUNT, 32'h10);
    rd(R_COUNT, v); check("coll_count_wr", v, 32'h10);
    @(negedge clk);
    rd(R_COUNT, v); check("count_resume", v, 32'h11);

    // wrap and alias
    wr(R_CMP, 32'd5);
    wr(R_CTRL, 32'hF);
    wr(R_COUNT, 32'hFFFF_FFFF);
    rd(R_COUNT, v);      check("wrap_pre", v, 32'hFFFF_FFFF);
    rd(32'h2000_0014, v); check("alias_count", v, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(R_COUNT, v); check("wrap_zero", v, 32'd0);
    rd(R_CTRL, v);  check("wrap_nopend", v, 32'h7);

    // one-shot
    wr(R_CTRL, 32'h0);
    wr(R_PRESC, 32'd2);
    rd(R_PRESC, v); check("presc_rd", v, P);
    wr(R_COUNT, 32'd0);
    wr(R_CMP, 32'd2);
    wr(R_CTRL, 32'h3);
    rd(R_COUNT, v); check("os_start", v, 32'd0);
    kmax = 3 * (P + 1) + 2;
    for (int k = 1; k <= kmax; k++) begin
      @(negedge clk);
      ec = k / (P + 1);
      if (ec > 2) ec = 2;
      rd(R_COUNT, v); check("os_count", v, ec);
    end
    rd(R_CTRL, v); check("os_ctrl", v, 32'hA);
    check("os_int", {31'd0, int_sig_o}, 32'h1);

    // async reset mid-count
    wr(R_PRESC, 32'd0);
    wr(R_COUNT, 32'd5);
    wr(R_CTRL, 32'h7);
    @(negedge clk);
    @(negedge clk);
    rd(R_COUNT, v); check("pre_rst_count", v, 32'd7);
    check("pre_rst_int", {31'd0, int_sig_o}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    rd(R_COUNT, v); check("arst_count", v, 32'd0);
    check("arst_int", {31'd0, int_sig_o}, 32'h0);
    rd(R_CTRL, v);  check("arst_ctrl", v, 32'h0);
    rd(R_CMP, v);   check("arst_cmp", v, 32'hFFFF_FFFF);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule

// File: doc/rib_timer.md
# rib_timer

Memory-mapped 32-bit timer that responds as a RIB slave on the timer slot (address region 0x2xxx_xxxx) of the RIB interconnect. It gives software a free-running or one-shot up-counter with a programmable prescaler, a compare register and a level interrupt to the core. Reads are combinational so they complete in the same cycle as the bus access; writes commit on the next clock edge.

## Interface
Parameters:
- `CNT_W`, default 32: width of COUNT and CMP. Must be 1..32; narrower values zero-extend on reads.
- `PRESC_W`, default 16: width of PRESC.

Ports:
- `clk`  in  1  single clock domain.
- `rst`  in  1  reset, asynchronous and active-high.
- `addr_i`  in  32  byte address from the bus. The interconnect has already cleared bits [31:28].
- `data_i`  in  32  write data.
- `data_o`  out  32  read data. Combinational from `addr_i`.
- `we_i`  in  1  write strobe. Sampled on `clk` rising edge.
- `int_sig_o`  out  1  registered interrupt request, level, active-high.

## Operation
- Register decode uses `addr_i[3:2]`.
  - Bits [27:4] are ignored, so the register block aliases every 16 bytes.
  - Bits [1:0] are ignored.
  - All accesses are full-word.
- Register map:
  - 0x0 CTRL
    - bit0 EN: count enable.
    - bit1 IE: interrupt enable.
    - bit2 AR: 1 = auto-reload, 0 = one-shot.
    - bit3 PEND: match pending. Reads the flag; writing 1 clears it, writing 0 has no effect.
    - Bits [31:4] read 0.
  - 0x4 COUNT: current count. Read/write.
  - 0x8 CMP: compare value. Read/write.
  - 0xC PRESC: prescale divisor minus 1. Read/write.
- Prescaler:
  - Internal counter `pcnt` (`PRESC_W` bits) counts while EN=1.
  - When `pcnt==PRESC`, a one-cycle `tick` is generated and `pcnt` returns to 0.
  - `pcnt` is cleared whenever EN=0 or PRESC is written.
- Counter, evaluated on `tick`:
  - If `COUNT==CMP`: PEND is set.
    - AR=1: COUNT ← 0.
    - AR=0: COUNT holds and EN ← 0 (one-shot stop).
  - Otherwise COUNT ← COUNT+1, wrapping modulo 2^CNT_W.
- Interrupt: `int_sig_o` ← PEND & IE, registered one cycle after the PEND/IE update.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the write wins and no increment happens.
  - Hardware match setting PEND in the same cycle as a W1C write to CTRL: the set wins, PEND stays 1. The other CTRL bits still take the written values.
  - Bus write to CTRL clearing EN in the same cycle as a tick: the tick is discarded.
  - CMP written equal to the current COUNT: the match fires on the next tick, not immediately.
- Writes with `we_i=1` never block. The block never drives the pipeline hold.

## Timing
- Reset (asynchronous assert, deassert synchronous to `clk`):
  - CTRL=0, COUNT=0, CMP=0xFFFF_FFFF (truncated to `CNT_W`), PRESC=0.
  - `pcnt`=0, `int_sig_o`=0.
  - `data_o` then reflects the reset register values combinationally.
- Read latency is 0 cycles. Write latency is 1 edge.
- With PRESC=P and EN set at edge T:
  - The first tick is at edge T+P+1.
  - Ticks then repeat every P+1 cycles.
- A match tick at edge T sets PEND at T and asserts `int_sig_o` at T+1.
- Reset asserted mid-count forces all state to reset values immediately, independent of `clk`.

## Configuration
- `RIB_TIMER_PRESC_EN` defined:
  - PRESC register and `pcnt` exist as described.
- `RIB_TIMER_PRESC_EN` undefined:
  - No prescaler; `tick` = EN every cycle.
  - PRESC reads 0 and writes to it are ignored.
  - `PRESC_W` is unused.

## Test plan
- Reset, then read 0x0/0x4/0x8/0xC -> 0x0, 0x0, 0xFFFF_FFFF, 0x0; `int_sig_o`=0.
- Auto-reload period: PRESC=0, CMP=3, CTRL=0x7 -> COUNT steps 1,2,3,0,1… once per cycle; PEND sets on each match; `int_sig_o` rises 1 cycle after the first match. Writing CTRL=0xF clears PEND and `int_sig_o` drops 1 cycle later.
- One-shot with prescaler: PRESC=2, CMP=2, CTRL=0x3 -> COUNT increments every 3 cycles; at COUNT=2 the match sets PEND and clears EN; COUNT holds at 2 thereafter.
- Collisions:
  - W1C of PEND on the same edge as a match -> PEND reads 1.
  - Write COUNT=0x10 on a tick edge -> COUNT reads 0x10, not 0x11.
- Wrap and alias: COUNT=0xFFFF_FFFF, CMP=5, PRESC=0, EN=1 -> COUNT becomes 0 on the next tick with no PEND. A read at address 0x2000_0014 returns COUNT.
- Async reset mid-count: assert `rst` between clock edges with COUNT=7 and `int_sig_o`=1 -> both read 0 immediately, with no clock edge required.
